kernel_window_builder: RTL and testbench

//  Builds the 5x5 sliding pixel window consumed by the Gx/Gy gradient stage from a raster pixel stream.

---
 rtl/gradient_pkg.sv | 10 +
 rtl/kernel_line_buffer.sv | 19 +
 rtl/kernel_window_builder.sv | 104 ++++++++++
 tb/tb_kernel_window_builder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gradient_pkg.sv
// Shared defaults and pixel/window types for the gradient pipeline.
package gradient_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int KERNEL_SIZE = 5;
  localparam int IMG_WIDTH   = 640;
  localparam int IMG_HEIGHT  = 480;

  typedef logic [DATA_WIDTH-1:0] pixel_t;
  typedef pixel_t [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1] kernel_window_t;
endpackage

// File: rtl/kernel_line_buffer.sv
// One image line of storage: combinational read at i_addr, write on i_wr_en. Contents are not reset.
module kernel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  output logic [WIDTH-1:0]         o_rd_data
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_addr] <= i_wr_data;
  end

  assign o_rd_data = mem_q[i_addr];
endmodule

// File: rtl/kernel_window_builder.sv
// Builds a KxK sliding window from a raster pixel stream using K-1 cascaded line buffers.
module kernel_window_builder
  import gradient_pkg::*;
#(
  parameter int DATA_WIDTH  = gradient_pkg::DATA_WIDTH,
  parameter int KERNEL_SIZE = gradient_pkg::KERNEL_SIZE,
  parameter int IMG_WIDTH   = gradient_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT  = gradient_pkg::IMG_HEIGHT
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic [DATA_WIDTH-1:0] i_pixel,
  input  logic                  i_pixel_valid,
  input  logic                  i_start_of_frame,
  output logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] o_image_kernel_buffer,
  output logic                  o_data_valid,
  output logic                  o_start_of_frame
);
  localparam int CW  = $clog2(IMG_WIDTH);
  localparam int RW  = $clog2(IMG_HEIGHT + 1);
  localparam int NLB = KERNEL_SIZE - 1;

  logic [CW-1:0] col_cnt_q, col_cnt_d, cur_col;
  logic [RW-1:0] row_cnt_q, row_cnt_d, cur_row;
  logic          frame_active_q, frame_active_d;
  logic          sof_acc, acc;
  logic          valid_q, valid_d, sof_q, sof_d;
  logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] win_q, win_d;
  logic [DATA_WIDTH-1:0] lb_rd  [NLB];
  logic [DATA_WIDTH-1:0] lb_wr  [NLB];
  logic [DATA_WIDTH-1:0] col_vec[KERNEL_SIZE];

  // SOF always restarts at (0,0); otherwise pixels count only inside an unfinished frame.
  assign sof_acc = i_pixel_valid && i_start_of_frame;
  assign acc     = sof_acc || (frame_active_q && i_pixel_valid && (row_cnt_q < RW'(IMG_HEIGHT)));
  assign cur_col = sof_acc ? '0 : col_cnt_q;
  assign cur_row = sof_acc ? '0 : row_cnt_q;

  for (genvar k = 0; k < NLB; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_wr[k] = i_pixel;
    end else begin : g_tail
      assign lb_wr[k] = lb_rd[k-1];
    end
    kernel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb (
      .i_clk     (i_clk),
      .i_wr_en   (acc),
      .i_addr    (cur_col),
      .i_wr_data (lb_wr[k]),
      .o_rd_data (lb_rd[k])
    );
  end

  always_comb begin
    for (int r = 0; r < NLB; r++) col_vec[r] = lb_rd[NLB-1-r];
    col_vec[KERNEL_SIZE-1] = i_pixel;
  end

  always_comb begin
    win_d          = win_q;
    col_cnt_d      = col_cnt_q;
    row_cnt_d      = row_cnt_q;
    frame_active_d = frame_active_q || sof_acc;
    valid_d        = 1'b0;
    sof_d          = 1'b0;
    if (acc) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][KERNEL_SIZE-1] = col_vec[r];
      end
      if (cur_col == CW'(IMG_WIDTH - 1)) begin
        col_cnt_d = '0;
        row_cnt_d = cur_row + RW'(1);
      end else begin
        col_cnt_d = cur_col + CW'(1);
        row_cnt_d = cur_row;
      end
      valid_d = (cur_row >= RW'(KERNEL_SIZE - 1)) && (cur_col >= CW'(KERNEL_SIZE - 1));
      sof_d   = (cur_row == RW'(KERNEL_SIZE - 1)) && (cur_col == CW'(KERNEL_SIZE - 1));
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      col_cnt_q      <= '0;
      row_cnt_q      <= '0;
      frame_active_q <= 1'b0;
      valid_q        <= 1'b0;
      sof_q          <= 1'b0;
      win_q          <= '0;
    end else begin
      col_cnt_q      <= col_cnt_d;
      row_cnt_q      <= row_cnt_d;
      frame_active_q <= frame_active_d;
      valid_q        <= valid_d;
      sof_q          <= sof_d;
      win_q          <= win_d;
    end
  end

  assign o_image_kernel_buffer = win_q;
  assign o_data_valid          = valid_q;
  assign o_start_of_frame      = sof_q;
endmodule

// File: tb/tb_kernel_window_builder.sv
// Directed + randomized checks of kernel_window_builder against an image-array reference model.
module tb_kernel_window_builder;
  localparam int DW = 8;
  localparam int K  = 5;
  localparam int W  = 8;
  localparam int H  = 6;

  typedef logic [0:K-1][0:K-1][DW-1:0] win_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] pix;
  logic          pix_v;
  logic          pix_sof;
  win_t          win_o;
  logic          dv_o;
  logic          sof_o;

  always #5 clk = ~clk;

  kernel_window_builder #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk                 (clk),
    .i_aresetn             (rst_n),
    .i_pixel               (pix),
    .i_pixel_valid         (pix_v),
    .i_start_of_frame      (pix_sof),
    .o_image_kernel_buffer (win_o),
    .o_data_valid          (dv_o),
    .o_start_of_frame      (sof_o)
  );

  int vectors = 0;
  int errors  = 0;
  int pulses  = 0;

  // Reference model: the frame as a 2-D image plus the raster position of the next pixel.
  logic [DW-1:0] img [H][W];
  bit   m_active = 0;
  int   m_row = 0;
  int   m_col = 0;
  win_t exp_win = '0;
  bit   win_known = 1;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input win_t obs, input win_t exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic win_t pattern_win(input int ro, input int co);
    win_t w;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) w[r][c] = DW'((r + ro) * 16 + (c + co));
    return w;
  endfunction

  task automatic step(input bit v, input bit s, input logic [DW-1:0] p);
    bit acc;
    bit exp_v;
    bit exp_s;
    int r;
    int c;
    @(negedge clk);
    pix_v   = v;
    pix_sof = s;
    pix     = p;
    acc   = v && (s || (m_active && m_row < H));
    exp_v = 0;
    exp_s = 0;
    if (acc) begin
      if (s) begin
        m_active = 1;
        r = 0;
        c = 0;
      end else begin
        r = m_row;
        c = m_col;
      end
      img[r][c] = p;
      exp_v = (r >= K - 1) && (c >= K - 1);
      exp_s = (r == K - 1) && (c == K - 1);
      if (exp_v)
        for (int rr = 0; rr < K; rr++)
          for (int cc = 0; cc < K; cc++) exp_win[rr][cc] = img[r-K+1+rr][c-K+1+cc];
      win_known = exp_v;
      c++;
      if (c == W) begin
        c = 0;
        r++;
      end
      m_row = r;
      m_col = c;
    end
    @(posedge clk);
    #1;
    if (dv_o === 1'b1) pulses++;
    chk_bit("data_valid", dv_o, exp_v);
    chk_bit("start_of_frame", sof_o, exp_s);
    if (win_known) chk_win(exp_v ? "window" : "window_hold", win_o, exp_win);
  endtask

  task automatic send_pixels(input int n, input int gap_max, input bit rnd);
    for (int i = 0; i < n; i++) begin
      int r;
      int c;
      r = i / W;
      c = i % W;
      repeat ($urandom_range(0, gap_max)) step(0, 0, DW'($urandom));
      step(1, i == 0, rnd ? DW'($urandom) : DW'(r * 16 + c));
      if (!rnd && r == K - 1 && c == K - 1) chk_win("first_win", win_o, pattern_win(0, 0));
      if (!rnd && r == H - 1 && c == W - 1) chk_win("last_win", win_o, pattern_win(1, 3));
    end
  endtask

  task automatic full_frame(input string tag, input int gap_max, input bit rnd);
    pulses = 0;
    send_pixels(W * H, gap_max, rnd);
    step(0, 0, '0);
    chk_int(tag, pulses, (W - K + 1) * (H - K + 1));
  endtask

  initial begin
    rst_n   = 1'b0;
    pix     = '0;
    pix_v   = 1'b0;
    pix_sof = 1'b0;
    #12;
    chk_bit("reset_valid", dv_o, 1'b0);
    chk_bit("reset_sof", sof_o, 1'b0);
    chk_win("reset_window", win_o, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pixels before any SOF are ignored, then a clean frame.
    pulses = 0;
    for (int i = 0; i < 10; i++) step(1, 0, DW'($urandom));
    chk_int("pre_sof_pulses", pulses, 0);
    full_frame("t1_count", 0, 0);

    // Random idle gaps.
    full_frame("t2_count", 3, 0);

    // SOF restart mid-frame at (3,2).
    pulses = 0;
    send_pixels(3 * W + 2, 0, 0);
    full_frame("t4_count", 0, 0);

    // Excess pixels after the last line produce nothing.
    pulses = 0;
    for (int i = 0; i < 10; i++) step(1, 0, DW'($urandom));
    chk_int("excess_pulses", pulses, 0);
    full_frame("t5_count", 0, 0);

    // Asynchronous reset while pixel (4,5) is presented.
    send_pixels(4 * W + 5, 0, 0);
    @(negedge clk);
    pix_v   = 1'b1;
    pix_sof = 1'b0;
    pix     = DW'(4 * 16 + 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("async_rst_valid", dv_o, 1'b0);
    chk_bit("async_rst_sof", sof_o, 1'b0);
    chk_win("async_rst_window", win_o, '0);
    m_active  = 0;
    m_row     = 0;
    m_col     = 0;
    exp_win   = '0;
    win_known = 1;
    @(negedge clk);
    pix_v = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 0, DW'($urandom));
    full_frame("t6_count", 0, 0);

    // Random pixel data with random gaps, twice.
    full_frame("rand_count_a", 3, 1);
    full_frame("rand_count_b", 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
